matrix_issue_ctrl: RTL and testbench
====================================

# matrix_issue_ctrl

Sequential issue controller for the custom matrix extension (opcode 7'b1110111), parametrised in matrix dimension, data width and engine timeout. Sits beside the decode-stage control decoder: it streams LMA/LMB operands element by element into the A/B matrix buffers with auto-incrementing row/column indices. It launches the MATMUL/MATINV engines with a start/done handshake and stalls the pipeline while an engine runs. It returns a status writeback for the issuing instruction.

## Interface
- N, 4: matrix dimension, 2..16; A and B are N×N.
- DATA_W, 32: element and register width.
- TIMEOUT, 1023: maximum engine cycles before abort, at least 1.
- IDX_W, $clog2(N): row/column index width (derived, not overridden).

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr  in  32  instruction in decode.
- instr_valid  in  1  instr is a real instruction (not a bubble or flush).
- If_Id_Write  in  1  hazard unit permits decode to advance; acceptance requires 1.
- rs1_data  in  DATA_W  operand for LMA/LMB.
- stall_out  out  1  hold IF/ID and PC.
- ld_en  out  1  one-cycle element write strobe.
- ld_sel  out  1  0 = matrix A, 1 = matrix B.
- ld_row, ld_col  out  IDX_W each  element position.
- ld_data  out  DATA_W  element value.
- eng_start  out  1  one-cycle engine launch.
- eng_op  out  1  0 = MATMUL, 1 = MATINV; held from START through WAIT.
- eng_done  in  1  engine completion, honoured only in WAIT.
- wb_valid  out  1  one-cycle status writeback.
- wb_rd  out  5  destination, latched instr[11:7].
- wb_status  out  2  0 ok, 1 operand matrix not loaded, 2 timeout.
- a_full, b_full  out  1 each  matrix fully loaded.
- err  out  1  one-cycle illegal-encoding or timeout pulse.

## Operation
- accept = instr_valid & If_Id_Write & instr[6:0]==7'b1110111 & state==IDLE.
- Decode uses instr[31:30] and instr[14:12]:
  - 00/000 = LMA.
  - 00/001 = LMB.
  - 01 = MATINV.
  - 10 = MATMUL.
  - Anything else is illegal: err pulses the next cycle, no other effect.
- LMA/LMB (per matrix: row, col counters and a full flag):
  - On accept, the next cycle drives ld_en=1, ld_sel, ld_row/ld_col = current counters, and ld_data = rs1_data as captured at accept.
  - col increments; at N-1 col wraps to 0 and row increments.
  - At (N-1, N-1) both wrap to 0 and the full flag sets.
  - Writing element (0,0) clears the full flag (a reload has begun).
  - No stall; back-to-back loads are accepted every cycle.
- FSM states IDLE, START, WAIT, WB:
  - IDLE→START on accepted MATMUL when a_full&b_full, or accepted MATINV when a_full. The block latches wb_rd and eng_op.
  - IDLE→WB with status 1 when the required matrix is not full.
  - START: eng_start=1 for exactly one cycle, then → WAIT; the timeout counter clears.
  - WAIT: eng_done=1 → WB with status 0. Otherwise the counter increments; at TIMEOUT → WB with status 2 and an err pulse.
  - WB: wb_valid=1 for one cycle, then → IDLE.
- stall_out = (state∈{START,WAIT}) | (accept & op∈{MATMUL,MATINV}).
  - stall_out is low in WB, so the held instruction retires there.
  - No re-accept occurs in WB because state≠IDLE.
- Full flags persist across MATMUL/MATINV.

## Timing
- Reset value of every output and all state is 0: IDLE, counters 0, full flags 0, ld_*/eng_*/wb_*/err all 0.
- Reset asserted mid-operation aborts immediately to IDLE; no wb_valid is issued for the aborted op.
- Load latency: ld_en is registered, 1 cycle after accept.
- MATMUL/MATINV with eng_done returned k cycles after eng_start (k≥1):
  - wb_valid rises at cycle accept+2+k.
  - stall_out is high from the accept cycle through accept+1+k.
- eng_done asserted during START or IDLE is ignored.
- Timeout: wb_valid occurs at accept+2+TIMEOUT when no done arrives.
- If_Id_Write=0 blocks acceptance but does not freeze a running FSM.
- instr_valid=0 (flushed slot) is never accepted.

## Test plan
- Sixteen back-to-back LMA with rs1_data=1..16 (N=4) -> ld_en on 16 consecutive cycles; (row,col) runs (0,0)..(3,3) row-major; a_full rises after the 16th; the 17th LMA writes (0,0) and clears a_full.
- MATMUL with A and B full, eng_done returned 5 cycles after eng_start -> eng_start is a single pulse; stall_out is high for 7 cycles; wb_valid with wb_status=0 and wb_rd=instr[11:7].
- MATMUL with only A loaded -> stall for 1 cycle, wb_valid with wb_status=1, eng_start never pulses.
- MATINV with TIMEOUT=8 and eng_done never asserted -> wb_status=2, err pulse, wb_valid exactly 10 cycles after accept.
- rst_n dropped in WAIT -> all outputs 0 at once; a_full=0; a later MATINV returns status 1.
- Opcode 1110111 with instr[31:30]=11, plus a MATMUL with If_Id_Write=0 -> the first gives one err pulse and no stall; the second is not accepted until If_Id_Write=1.

Source files
------------

// File: rtl/matrix_issue_ctrl_if.sv
// Decode-stage, load-port, engine and writeback signals of the matrix issue controller.
// The master side is the pipeline/engine environment; the controller takes the slave side.
interface matrix_issue_ctrl_if #(
  parameter int N      = 4,
  parameter int DATA_W = 32
);
  localparam int IDX_W = $clog2(N);

  logic [31:0]       instr;
  logic              instr_valid;
  logic              If_Id_Write;
  logic [DATA_W-1:0] rs1_data;
  logic              stall_out;
  logic              ld_en;
  logic              ld_sel;
  logic [IDX_W-1:0]  ld_row;
  logic [IDX_W-1:0]  ld_col;
  logic [DATA_W-1:0] ld_data;
  logic              eng_start;
  logic              eng_op;
  logic              eng_done;
  logic              wb_valid;
  logic [4:0]        wb_rd;
  logic [1:0]        wb_status;
  logic              a_full;
  logic              b_full;
  logic              err;

  modport master (
    output instr, instr_valid, If_Id_Write, rs1_data, eng_done,
    input  stall_out, ld_en, ld_sel, ld_row, ld_col, ld_data, eng_start, eng_op,
           wb_valid, wb_rd, wb_status, a_full, b_full, err
  );

  modport slave (
    input  instr, instr_valid, If_Id_Write, rs1_data, eng_done,
    output stall_out, ld_en, ld_sel, ld_row, ld_col, ld_data, eng_start, eng_op,
           wb_valid, wb_rd, wb_status, a_full, b_full, err
  );
endinterface

// File: rtl/matrix_issue_ctrl.sv
// Issue controller for the matrix extension: streams LMA/LMB elements into the A/B
// buffers and sequences MATMUL/MATINV engine runs with a status writeback.
module matrix_issue_ctrl #(
  parameter int N       = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst_n,
  matrix_issue_ctrl_if.slave  bus
);
  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [6:0]       OPC      = 7'b1110111;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, WB} state_t;
  typedef enum logic [2:0] {OP_LMA, OP_LMB, OP_INV, OP_MUL, OP_ILL} op_t;

  state_t state, next_state;
  op_t    op;
  logic   accept, acc_load, acc_mat, ready, sel;
  logic [CNT_W-1:0]           cnt;
  logic [1:0][IDX_W-1:0]      row, col;
  logic [1:0]                 full;
  logic [IDX_W-1:0]           cur_row, cur_col;
  logic [1:0]                 status_d;
  logic                       status_we, err_d;
  logic                       unused_bits;

  assign unused_bits = ^bus.instr[29:15];

  always_comb begin
    op = OP_ILL;
    case (bus.instr[31:30])
      2'b00: begin
        if (bus.instr[14:12] == 3'b000)      op = OP_LMA;
        else if (bus.instr[14:12] == 3'b001) op = OP_LMB;
      end
      2'b01:   op = OP_INV;
      2'b10:   op = OP_MUL;
      default: op = OP_ILL;
    endcase
  end

  assign accept   = rst_n & bus.instr_valid & bus.If_Id_Write &
                    (bus.instr[6:0] == OPC) & (state == IDLE);
  assign acc_load = accept & ((op == OP_LMA) | (op == OP_LMB));
  assign acc_mat  = accept & ((op == OP_INV) | (op == OP_MUL));
  assign sel      = (op == OP_LMB);
  assign ready    = full[0] & (full[1] | (op == OP_INV));
  assign cur_row  = row[sel];
  assign cur_col  = col[sel];

  assign bus.a_full    = full[0];
  assign bus.b_full    = full[1];
  assign bus.stall_out = (state == START) | (state == WAIT) | acc_mat;

  // Element loader: the strobe carries the pre-increment position; (0,0) starts a reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ld_en   <= 1'b0;
      bus.ld_sel  <= 1'b0;
      bus.ld_row  <= '0;
      bus.ld_col  <= '0;
      bus.ld_data <= '0;
      row         <= '0;
      col         <= '0;
      full        <= '0;
    end else begin
      bus.ld_en <= acc_load;
      if (acc_load) begin
        bus.ld_sel  <= sel;
        bus.ld_row  <= cur_row;
        bus.ld_col  <= cur_col;
        bus.ld_data <= bus.rs1_data;
        if (cur_col == IDX_LAST) begin
          col[sel] <= '0;
          row[sel] <= (cur_row == IDX_LAST) ? '0 : cur_row + 1'b1;
        end else begin
          col[sel] <= cur_col + 1'b1;
        end
        if ((cur_row == IDX_LAST) && (cur_col == IDX_LAST))
          full[sel] <= 1'b1;
        else if ((cur_row == '0) && (cur_col == '0))
          full[sel] <= 1'b0;
      end
    end
  end

  always_comb begin
    next_state    = state;
    status_we     = 1'b0;
    status_d      = '0;
    err_d         = 1'b0;
    bus.eng_start = 1'b0;
    bus.wb_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (acc_mat) begin
          if (ready) begin
            next_state = START;
          end else begin
            next_state = WB;
            status_we  = 1'b1;
            status_d   = 2'd1;
          end
        end
        if (accept && (op == OP_ILL)) err_d = 1'b1;
      end
      START: begin
        bus.eng_start = 1'b1;
        next_state    = WAIT;
      end
      WAIT: begin
        if (bus.eng_done) begin
          next_state = WB;
          status_we  = 1'b1;
          status_d   = 2'd0;
        end else if (cnt == CNT_LAST) begin
          next_state = WB;
          status_we  = 1'b1;
          status_d   = 2'd2;
          err_d      = 1'b1;
        end
      end
      WB: begin
        bus.wb_valid = 1'b1;
        next_state   = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.err       <= 1'b0;
      bus.wb_status <= '0;
      bus.wb_rd     <= '0;
      bus.eng_op    <= 1'b0;
    end else begin
      state   <= next_state;
      bus.err <= err_d;
      if (state == START)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt + 1'b1;
      if (status_we) bus.wb_status <= status_d;
      if (acc_mat) begin
        bus.wb_rd  <= bus.instr[11:7];
        bus.eng_op <= (op == OP_INV);
      end
    end
  end
endmodule

// File: tb/tb_matrix_issue_ctrl.sv
// Bench for matrix_issue_ctrl: a phase-based behavioural model checked every cycle,
// plus directed scenarios with hand-computed latencies and values.
module tb_matrix_issue_ctrl;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam logic [6:0] OPC = 7'b1110111;
  localparam int K_LMA = 0, K_LMB = 1, K_INV = 2, K_MUL = 3, K_ILL = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_issue_ctrl_if #(.N(N), .DATA_W(DW)) bus ();
  matrix_issue_ctrl #(.N(N), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int kind(input logic [31:0] i);
    if (i[31:30] == 2'b01) return K_INV;
    if (i[31:30] == 2'b10) return K_MUL;
    if (i[31:30] == 2'b00 && i[14:12] == 3'b000) return K_LMA;
    if (i[31:30] == 2'b00 && i[14:12] == 3'b001) return K_LMB;
    return K_ILL;
  endfunction

  function automatic logic [31:0] mk(input logic [1:0] f2, input logic [2:0] f3, input logic [4:0] rd);
    return {f2, 15'd0, f3, rd, OPC};
  endfunction

  // Model: element counts per matrix; an op is tracked by its phase (cycles since accept)
  // and the phase at which its writeback is due (-1 while still unknown).
  int          idx[2]  = '{0, 0};
  bit          full[2] = '{0, 0};
  bit          busy = 0;
  int          ph = 0, wbph = -1, st = 0;
  logic [4:0]  m_rd = '0;
  bit          m_op = 0;
  bit          e_ld_en = 0, e_sel = 0, e_err = 0;
  int          e_row = 0, e_col = 0;
  logic [31:0] e_data = '0;

  always @(posedge clk or negedge rst_n) begin
    bit acc;
    int k, s;
    if (!rst_n) begin
      idx[0] = 0; idx[1] = 0; full[0] = 0; full[1] = 0;
      busy = 0; ph = 0; wbph = -1; st = 0;
      e_ld_en = 0; e_err = 0;
    end else begin
      k   = kind(bus.instr);
      acc = bus.instr_valid && bus.If_Id_Write && (bus.instr[6:0] == OPC) && !busy;
      e_ld_en = 0;
      e_err   = 0;
      if (busy) begin
        if (ph == wbph) begin
          busy = 0;
        end else begin
          if (wbph < 0 && ph >= 2) begin
            if (bus.eng_done)      begin wbph = ph + 1; st = 0; end
            else if (ph == TO + 1) begin wbph = ph + 1; st = 2; e_err = 1; end
          end
          ph++;
        end
      end
      if (acc) begin
        if (k == K_LMA || k == K_LMB) begin
          s = (k == K_LMB) ? 1 : 0;
          e_ld_en = 1; e_sel = s[0];
          e_row = idx[s] / N; e_col = idx[s] % N; e_data = bus.rs1_data;
          if (idx[s] == 0) full[s] = 0;
          idx[s]++;
          if (idx[s] == N * N) begin idx[s] = 0; full[s] = 1; end
        end else if (k == K_INV || k == K_MUL) begin
          busy = 1; ph = 1; m_rd = bus.instr[11:7]; m_op = (k == K_INV);
          if (full[0] && (full[1] || k == K_INV)) wbph = -1;
          else begin wbph = 1; st = 1; end
        end else begin
          e_err = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit acc_now, running, e_wb;
    int k;
    if (!rst_n) begin
      chk("rst_stall", bus.stall_out, 0);  chk("rst_ld_en", bus.ld_en, 0);
      chk("rst_ld_sel", bus.ld_sel, 0);    chk("rst_ld_row", bus.ld_row, 0);
      chk("rst_ld_col", bus.ld_col, 0);    chk("rst_ld_data", bus.ld_data, 0);
      chk("rst_eng_start", bus.eng_start, 0); chk("rst_eng_op", bus.eng_op, 0);
      chk("rst_wb_valid", bus.wb_valid, 0);   chk("rst_wb_rd", bus.wb_rd, 0);
      chk("rst_wb_status", bus.wb_status, 0); chk("rst_a_full", bus.a_full, 0);
      chk("rst_b_full", bus.b_full, 0);    chk("rst_err", bus.err, 0);
    end else begin
      k       = kind(bus.instr);
      acc_now = bus.instr_valid && bus.If_Id_Write && (bus.instr[6:0] == OPC) && !busy;
      running = busy && (wbph < 0 || ph < wbph);
      e_wb    = busy && (ph == wbph);
      chk("stall", bus.stall_out, running || (acc_now && (k == K_INV || k == K_MUL)));
      chk("eng_start", bus.eng_start, busy && ph == 1 && wbph < 0);
      chk("wb_valid", bus.wb_valid, e_wb);
      chk("err", bus.err, e_err);
      chk("ld_en", bus.ld_en, e_ld_en);
      chk("a_full", bus.a_full, full[0]);
      chk("b_full", bus.b_full, full[1]);
      if (running) chk("eng_op", bus.eng_op, m_op);
      if (e_wb) begin
        chk("wb_status", bus.wb_status, st);
        chk("wb_rd", bus.wb_rd, m_rd);
      end
      if (e_ld_en) begin
        chk("ld_sel", bus.ld_sel, e_sel);
        chk("ld_row", bus.ld_row, e_row);
        chk("ld_col", bus.ld_col, e_col);
        chk("ld_data", bus.ld_data, e_data);
      end
    end
  end

  task automatic issue(input logic [31:0] ins, input logic [31:0] d, output bit stl);
    bus.instr = ins; bus.rs1_data = d; bus.instr_valid = 1'b1; bus.If_Id_Write = 1'b1;
    @(negedge clk);
    stl = bus.stall_out;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
  endtask

  // Observe cycles accept+1..accept+lim; eng_done is driven in cycles d1 and d2.
  task automatic watch(input int d1, input int d2, input int lim, output int wb_i,
                       output int n_start, output int n_stall, output int err_i,
                       output logic [1:0] ws, output logic [4:0] wr);
    wb_i = -1; n_start = 0; n_stall = 0; err_i = -1; ws = '0; wr = '0;
    for (int i = 1; i <= lim; i++) begin
      bus.eng_done = (i == d1) || (i == d2);
      @(negedge clk);
      if (bus.eng_start) n_start++;
      if (bus.stall_out) n_stall++;
      if (bus.err && err_i < 0) err_i = i;
      if (bus.wb_valid && wb_i < 0) begin wb_i = i; ws = bus.wb_status; wr = bus.wb_rd; end
      @(posedge clk); #1;
    end
    bus.eng_done = 1'b0;
  endtask

  initial begin
    bit stl;
    int wb_i, ns, nst, ei;
    logic [1:0] ws;
    logic [4:0] wr;
    bus.instr = '0; bus.instr_valid = 1'b0; bus.If_Id_Write = 1'b1;
    bus.rs1_data = '0; bus.eng_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_a_full", bus.a_full, 0);
    chk("reset_stall", bus.stall_out, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    bus.eng_done = 1'b1;
    @(posedge clk); #1 bus.eng_done = 1'b0;

    for (int i = 1; i <= 16; i++) begin
      issue(mk(2'b00, 3'b000, 5'd0), i, stl);
      chk("lma_no_stall", stl, 0);
    end
    @(negedge clk);
    chk("lma16_en", bus.ld_en, 1);   chk("lma16_row", bus.ld_row, 3);
    chk("lma16_col", bus.ld_col, 3); chk("lma16_data", bus.ld_data, 16);
    chk("lma16_a_full", bus.a_full, 1);
    @(posedge clk); #1;
    issue(mk(2'b00, 3'b000, 5'd0), 17, stl);
    @(negedge clk);
    chk("lma17_row", bus.ld_row, 0); chk("lma17_col", bus.ld_col, 0);
    chk("lma17_data", bus.ld_data, 17); chk("lma17_a_full", bus.a_full, 0);
    @(posedge clk); #1;
    for (int i = 18; i <= 32; i++) issue(mk(2'b00, 3'b000, 5'd0), i, stl);

    issue(mk(2'b10, 3'b000, 5'd3), 0, stl);
    watch(0, 0, 6, wb_i, ns, nst, ei, ws, wr);
    chk("mm_nob_stall", stl + nst, 1);
    chk("mm_nob_wb_at", wb_i, 1);
    chk("mm_nob_status", ws, 1);
    chk("mm_nob_start", ns, 0);

    for (int i = 1; i <= 16; i++) issue(mk(2'b00, 3'b001, 5'd0), 100 + i, stl);
    @(negedge clk);
    chk("lmb16_b_full", bus.b_full, 1);
    chk("lmb16_sel", bus.ld_sel, 1);
    @(posedge clk); #1;

    issue(mk(2'b10, 3'b000, 5'd9), 0, stl);
    watch(6, 0, 12, wb_i, ns, nst, ei, ws, wr);
    chk("mm_stall_cycles", stl + nst, 7);
    chk("mm_start_pulses", ns, 1);
    chk("mm_wb_at", wb_i, 7);
    chk("mm_status", ws, 0);
    chk("mm_rd", wr, 9);

    issue(mk(2'b01, 3'b000, 5'd17), 0, stl);
    watch(0, 0, 14, wb_i, ns, nst, ei, ws, wr);
    chk("inv_to_wb_at", wb_i, 10);
    chk("inv_to_status", ws, 2);
    chk("inv_to_err_at", ei, 10);
    chk("inv_to_rd", wr, 17);

    issue(mk(2'b11, 3'b000, 5'd1), 0, stl);
    chk("ill11_stall", stl, 0);
    @(negedge clk); chk("ill11_err", bus.err, 1);
    @(posedge clk); #1;
    issue(mk(2'b00, 3'b010, 5'd1), 0, stl);
    @(negedge clk); chk("ill_f3_err", bus.err, 1);
    @(posedge clk); #1;

    bus.instr = mk(2'b10, 3'b000, 5'd4); bus.instr_valid = 1'b1; bus.If_Id_Write = 1'b0;
    repeat (3) begin
      @(negedge clk); chk("ifid0_stall", bus.stall_out, 0);
      @(posedge clk); #1;
    end
    bus.instr_valid = 1'b0; bus.If_Id_Write = 1'b1;
    @(negedge clk); chk("flush_stall", bus.stall_out, 0);
    @(posedge clk); #1;
    issue(mk(2'b10, 3'b000, 5'd4), 0, stl);
    chk("ifid1_stall", stl, 1);
    watch(1, 3, 8, wb_i, ns, nst, ei, ws, wr);
    chk("done_in_start_ignored_wb_at", wb_i, 4);
    chk("mm2_start_pulses", ns, 1);
    chk("mm2_rd", wr, 4);

    issue(mk(2'b01, 3'b000, 5'd2), 0, stl);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rstw_stall", bus.stall_out, 0); chk("rstw_wb_valid", bus.wb_valid, 0);
    chk("rstw_eng_start", bus.eng_start, 0); chk("rstw_a_full", bus.a_full, 0);
    chk("rstw_b_full", bus.b_full, 0); chk("rstw_err", bus.err, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    watch(0, 0, 3, wb_i, ns, nst, ei, ws, wr);
    chk("rstw_no_wb", wb_i, -1);
    issue(mk(2'b01, 3'b000, 5'd6), 0, stl);
    watch(0, 0, 5, wb_i, ns, nst, ei, ws, wr);
    chk("post_rst_inv_wb_at", wb_i, 1);
    chk("post_rst_inv_status", ws, 1);
    chk("post_rst_inv_start", ns, 0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
